alu_writeback: RTL and testbench

Writeback stage directly downstream of the 8-bit ALU. It captures the ALU result and carry into a one-entry pending slot, then commits them to an 8x8 general register file and a Z/N/C flag register. It exposes two combinational read ports that supply the ALU operands for the next instruction. A commit counter is provided for debug and performance visibility.

---
 rtl/alu_writeback_if.sv | 51 +++++
 rtl/alu_writeback.sv | 163 ++++++++++++++++
 tb/tb_alu_writeback.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_writeback_if
// Description : Bundle of the ALU-to-writeback handshake, read-port and
//               status signals. The master side drives the ALU result and
//               read addresses; the slave side is the writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_writeback_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
);
  // ALU result handshake
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;
  logic [ADDR_W-1:0] dest_addr;
  logic              wb_en;
  logic              flags_en;
  logic              stall;

  // Operand read ports
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;

  // Status
  logic              flag_z;
  logic              flag_n;
  logic              flag_c;
  logic              pend_valid;
  logic [CNT_W-1:0]  commit_count;

  modport master (
    output in_valid, alu_out, alu_carry, dest_addr, wb_en, flags_en, stall,
    output rd_addr_a, rd_addr_b,
    input  in_ready, rd_data_a, rd_data_b,
    input  flag_z, flag_n, flag_c, pend_valid, commit_count
  );

  modport slave (
    input  in_valid, alu_out, alu_carry, dest_addr, wb_en, flags_en, stall,
    input  rd_addr_a, rd_addr_b,
    output in_ready, rd_data_a, rd_data_b,
    output flag_z, flag_n, flag_c, pend_valid, commit_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
// Module      : alu_writeback
// Description : Writeback stage behind the 8-bit ALU. A one-entry pending
//               slot captures the ALU result, which then commits into an
//               8x8 register file and the Z/N/C flags. Two combinational read
//               ports supply the next instruction's operands, and a wrapping
//               commit counter gives debug visibility.
//               Optional macro WB_BYPASS_EN forwards the pending write to the
//               read ports before it commits.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_writeback #(
  parameter int DATA_W    = 8,
  parameter int REG_COUNT = 8,
  parameter int ADDR_W    = 3,
  parameter int CNT_W     = 16
) (
  input  wire logic      clock,
  input  wire logic      reset,
  alu_writeback_if.slave bus
);

  // Pending slot
  logic              pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0] pend_data_q,  pend_data_d;
  logic              pend_carry_q, pend_carry_d;
  logic [ADDR_W-1:0] pend_dest_q,  pend_dest_d;
  logic              pend_wb_q,    pend_wb_d;
  logic              pend_fl_q,    pend_fl_d;

  // Architectural state
  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_c_q, flag_c_d;
  logic [CNT_W-1:0]  commit_count_q, commit_count_d;

  // Handshake decode
  logic              in_ready;
  logic              accept;
  logic              commit;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;

  // The slot frees up whenever its current occupant is committing, so a
  // full slot can still take a new entry on the same edge.
  assign in_ready = !pend_valid_q || !bus.stall;
  assign accept   = bus.in_valid && in_ready;
  assign commit   = pend_valid_q && !bus.stall;

  // Pending slot: load on accept, drain on commit, otherwise hold
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_carry_d = pend_carry_q;
    pend_dest_d  = pend_dest_q;
    pend_wb_d    = pend_wb_q;
    pend_fl_d    = pend_fl_q;
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_data_d  = bus.alu_out;
      pend_carry_d = bus.alu_carry;
      pend_dest_d  = bus.dest_addr;
      pend_wb_d    = bus.wb_en;
      pend_fl_d    = bus.flags_en;
    end else if (commit) begin
      pend_valid_d = 1'b0;
    end
  end

  // Register file: write the pending data when it commits with wb_en
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (commit && pend_wb_q) begin
      regs_d[pend_dest_q] = pend_data_q;
    end
  end

  // Flags and commit counter update on commit
  always_comb begin
    flag_z_d       = flag_z_q;
    flag_n_d       = flag_n_q;
    flag_c_d       = flag_c_q;
    commit_count_d = commit_count_q;
    if (commit) begin
      // Counts every commit, including entries that write nothing
      commit_count_d = commit_count_q + CNT_W'(1);
      if (pend_fl_q) begin
        flag_z_d = (pend_data_q == '0);
        flag_n_d = pend_data_q[DATA_W-1];
        flag_c_d = pend_carry_q;
      end
    end
  end

  // State registers; reset discards any pending entry
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid_q   <= 1'b0;
      pend_data_q    <= '0;
      pend_carry_q   <= 1'b0;
      pend_dest_q    <= '0;
      pend_wb_q      <= 1'b0;
      pend_fl_q      <= 1'b0;
      flag_z_q       <= 1'b0;
      flag_n_q       <= 1'b0;
      flag_c_q       <= 1'b0;
      commit_count_q <= '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pend_valid_q   <= pend_valid_d;
      pend_data_q    <= pend_data_d;
      pend_carry_q   <= pend_carry_d;
      pend_dest_q    <= pend_dest_d;
      pend_wb_q      <= pend_wb_d;
      pend_fl_q      <= pend_fl_d;
      flag_z_q       <= flag_z_d;
      flag_n_q       <= flag_n_d;
      flag_c_q       <= flag_c_d;
      commit_count_q <= commit_count_d;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read port A: committed value, optionally overridden by the pending write
  always_comb begin
    rd_data_a = regs_q[bus.rd_addr_a];
`ifdef WB_BYPASS_EN
    if (pend_valid_q && pend_wb_q && (bus.rd_addr_a == pend_dest_q)) begin
      rd_data_a = pend_data_q;
    end
`endif
  end

  // Read port B: same forwarding rule, evaluated independently of port A
  always_comb begin
    rd_data_b = regs_q[bus.rd_addr_b];
`ifdef WB_BYPASS_EN
    if (pend_valid_q && pend_wb_q && (bus.rd_addr_b == pend_dest_q)) begin
      rd_data_b = pend_data_q;
    end
`endif
  end

  assign bus.in_ready     = in_ready;
  assign bus.rd_data_a    = rd_data_a;
  assign bus.rd_data_b    = rd_data_b;
  assign bus.flag_z       = flag_z_q;
  assign bus.flag_n       = flag_n_q;
  assign bus.flag_c       = flag_c_q;
  assign bus.pend_valid   = pend_valid_q;
  assign bus.commit_count = commit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_writeback
// Description : Self-checking bench for alu_writeback. A queue-based model of
//               the pending slot and architectural state is compared against
//               the DUT every cycle; directed sequences pin known values.
//               A narrow commit counter is used so wrap-around is exercised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_writeback;
  localparam int DATA_W    = 8;
  localparam int REG_COUNT = 8;
  localparam int ADDR_W    = 3;
  localparam int CNT_W     = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) wb_if ();

  alu_writeback #(
    .DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (wb_if)
  );

  typedef struct {
    logic [7:0] data;
    logic       carry;
    logic [2:0] dest;
    logic       wb;
    logic       fl;
  } entry_t;

  // Reference model state
  entry_t      pq[$];
  logic [7:0]  m_regs [REG_COUNT];
  logic        m_z = 1'b0, m_n = 1'b0, m_c = 1'b0;
  int unsigned m_count = 0;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] exp_read(input logic [2:0] a);
`ifdef WB_BYPASS_EN
    if (pq.size() != 0 && pq[0].wb && pq[0].dest == a) return pq[0].data;
`endif
    return m_regs[a];
  endfunction

  // Model: one pending slot as a queue; the old entry leaves before the new one joins
  always @(posedge clock) begin
    entry_t e;
    bit     ready;
    if (reset) begin
      pq.delete();
      for (int i = 0; i < REG_COUNT; i++) m_regs[i] = 8'h00;
      m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
      m_count = 0;
    end else begin
      ready = (pq.size() == 0) || !wb_if.stall;
      if (pq.size() != 0 && !wb_if.stall) begin
        e = pq.pop_front();
        if (e.wb) m_regs[e.dest] = e.data;
        if (e.fl) begin
          m_z = (e.data == 8'h00);
          m_n = e.data[7];
          m_c = e.carry;
        end
        m_count = (m_count + 1) % (1 << CNT_W);
      end
      if (wb_if.in_valid && ready) begin
        e.data = wb_if.alu_out; e.carry = wb_if.alu_carry; e.dest = wb_if.dest_addr;
        e.wb = wb_if.wb_en;     e.fl = wb_if.flags_en;
        pq.push_back(e);
      end
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge clock) begin
    if (check_en) begin
      chk("in_ready",     32'(wb_if.in_ready),     32'((pq.size() == 0) || !wb_if.stall));
      chk("pend_valid",   32'(wb_if.pend_valid),   32'(pq.size() != 0));
      chk("rd_data_a",    32'(wb_if.rd_data_a),    32'(exp_read(wb_if.rd_addr_a)));
      chk("rd_data_b",    32'(wb_if.rd_data_b),    32'(exp_read(wb_if.rd_addr_b)));
      chk("flag_z",       32'(wb_if.flag_z),       32'(m_z));
      chk("flag_n",       32'(wb_if.flag_n),       32'(m_n));
      chk("flag_c",       32'(wb_if.flag_c),       32'(m_c));
      chk("commit_count", 32'(wb_if.commit_count), m_count);
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [7:0] d, input logic c, input logic [2:0] dst,
                         input logic wb, input logic fl);
    wb_if.in_valid  = 1'b1;
    wb_if.alu_out   = d;
    wb_if.alu_carry = c;
    wb_if.dest_addr = dst;
    wb_if.wb_en     = wb;
    wb_if.flags_en  = fl;
  endtask

  initial begin
    logic [7:0] exp_r1;
    wb_if.in_valid = 1'b0; wb_if.alu_out = 8'h00; wb_if.alu_carry = 1'b0;
    wb_if.dest_addr = 3'd0; wb_if.wb_en = 1'b0; wb_if.flags_en = 1'b0;
    wb_if.stall = 1'b0; wb_if.rd_addr_a = 3'd0; wb_if.rd_addr_b = 3'd7;

    // Reset then idle
    next_cycle();
    next_cycle();
    reset = 1'b0;
    check_en = 1'b1;
    @(negedge clock);
    chk("rst in_ready", 32'(wb_if.in_ready), 32'd1);
    chk("rst pend_valid", 32'(wb_if.pend_valid), 32'd0);
    chk("rst count", 32'(wb_if.commit_count), 32'd0);
    chk("rst rd_b R7", 32'(wb_if.rd_data_b), 32'h00);

    // Single write 0x5A -> R3 with flags
    next_cycle();
    present(8'h5A, 1'b0, 3'd3, 1'b1, 1'b1);
    wb_if.rd_addr_a = 3'd3;
    next_cycle();
    wb_if.in_valid = 1'b0;
    next_cycle();
    @(negedge clock);
    chk("single R3", 32'(wb_if.rd_data_a), 32'h5A);
    chk("single ZNC", 32'({wb_if.flag_z, wb_if.flag_n, wb_if.flag_c}), 32'b000);
    chk("single count", 32'(wb_if.commit_count), 32'd1);

    // Flags only: zero with carry, then negative
    next_cycle();
    present(8'h00, 1'b1, 3'd3, 1'b0, 1'b1);
    next_cycle();
    present(8'h80, 1'b0, 3'd3, 1'b0, 1'b1);
    next_cycle();
    wb_if.in_valid = 1'b0;
    @(negedge clock);
    chk("flz ZNC", 32'({wb_if.flag_z, wb_if.flag_n, wb_if.flag_c}), 32'b101);
    chk("flz R3 kept", 32'(wb_if.rd_data_a), 32'h5A);
    next_cycle();
    @(negedge clock);
    chk("fln ZNC", 32'({wb_if.flag_z, wb_if.flag_n, wb_if.flag_c}), 32'b010);
    chk("fln count", 32'(wb_if.commit_count), 32'd3);

    // Back-to-back stream with a 3-cycle stall after the first accept
    next_cycle();
    wb_if.rd_addr_a = 3'd1;
    wb_if.rd_addr_b = 3'd2;
    present(8'h11, 1'b0, 3'd1, 1'b1, 1'b0);
    next_cycle();
    present(8'h22, 1'b0, 3'd2, 1'b1, 1'b0);
    wb_if.stall = 1'b1;
`ifdef WB_BYPASS_EN
    exp_r1 = 8'h11;
`else
    exp_r1 = 8'h00;
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("stall in_ready", 32'(wb_if.in_ready), 32'd0);
      chk("stall R1", 32'(wb_if.rd_data_a), 32'(exp_r1));
      chk("stall count", 32'(wb_if.commit_count), 32'd3);
      if (k < 2) next_cycle();
    end
    next_cycle();
    wb_if.stall = 1'b0;
    next_cycle();
    present(8'h33, 1'b0, 3'd3, 1'b1, 1'b0);
    next_cycle();
    wb_if.in_valid = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clock);
    chk("b2b R1", 32'(wb_if.rd_data_a), 32'h11);
    chk("b2b R2", 32'(wb_if.rd_data_b), 32'h22);
    chk("b2b count", 32'(wb_if.commit_count), 32'd6);
    next_cycle();
    wb_if.rd_addr_a = 3'd3;
    @(negedge clock);
    chk("b2b R3", 32'(wb_if.rd_data_a), 32'h33);

    // Bypass: 0x7F -> R5 held in the slot by stall
    next_cycle();
    wb_if.rd_addr_b = 3'd5;
    present(8'h7F, 1'b0, 3'd5, 1'b1, 1'b0);
    next_cycle();
    wb_if.in_valid = 1'b0;
    wb_if.stall = 1'b1;
    @(negedge clock);
`ifdef WB_BYPASS_EN
    chk("bypass R5", 32'(wb_if.rd_data_b), 32'h7F);
`else
    chk("nobypass R5", 32'(wb_if.rd_data_b), 32'h00);
`endif
    next_cycle();
    next_cycle();
    wb_if.stall = 1'b0;
    next_cycle();
    @(negedge clock);
    chk("bypass commit R5", 32'(wb_if.rd_data_b), 32'h7F);
    chk("bypass count", 32'(wb_if.commit_count), 32'd7);

    // Reset while an entry is pending and stalled
    next_cycle();
    wb_if.rd_addr_a = 3'd6;
    present(8'hAA, 1'b0, 3'd6, 1'b1, 1'b1);
    next_cycle();
    wb_if.in_valid = 1'b0;
    wb_if.stall = 1'b1;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    wb_if.stall = 1'b0;
    next_cycle();
    @(negedge clock);
    chk("rstmid R6", 32'(wb_if.rd_data_a), 32'h00);
    chk("rstmid R5", 32'(wb_if.rd_data_b), 32'h00);
    chk("rstmid pend", 32'(wb_if.pend_valid), 32'd0);
    chk("rstmid count", 32'(wb_if.commit_count), 32'd0);

    // Randomized traffic, including occasional resets and counter wrap
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      present(8'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom));
      wb_if.in_valid  = ($urandom_range(0, 9) < 7);
      wb_if.stall     = ($urandom_range(0, 3) == 0);
      wb_if.rd_addr_a = 3'($urandom_range(0, 7));
      wb_if.rd_addr_b = 3'($urandom_range(0, 7));
      reset           = ($urandom_range(0, 299) == 0);
    end
    next_cycle();
    reset = 1'b0;
    wb_if.in_valid = 1'b0;
    wb_if.stall = 1'b0;
    next_cycle();
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
